// File: rtl/instr_stream_encoder.sv
// -----------------------------------------------------------------------------
// instr_stream_encoder
//
// Program loader for the instruction memory. Accepts symbolic instruction
// requests (class + register/immediate fields), encodes each one into a 32-bit
// MIPS word and writes the words to consecutive word addresses, starting at
// BASE_ADDR for every session.
//
// Supported classes: 0=R, 1=LW, 2=SW, 3=ADDI, 4=BEQ, 5=J; 6 and 7 are illegal.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a load session (only honoured in IDLE)
//   in_valid   request present
//   in_ready   encoder accepts a request this cycle
//   in_class   instruction class
//   in_rs      source register
//   in_rt      target register
//   in_rd      destination register (R only)
//   in_funct   function field (R only)
//   in_imm     immediate/offset (LW, SW, ADDI, BEQ)
//   in_target  jump target (J only)
//   in_last    request ends the session
//   mem_we     instruction memory write strobe
//   mem_addr   instruction memory word address
//   mem_wdata  encoded instruction word
//   busy       high outside IDLE
//   done       one-cycle pulse at session end
//   full       sticky: top address written in this session
//   err        sticky: illegal class seen in this session
//   count      words written in the current session
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start
// LOAD   | in_ready high, waiting for a request
// WRITE  | one-cycle memory write of the captured word
// DONE   | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module instr_stream_encoder #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   next_addr_q, next_addr_d;   // address for the next word
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;     // address of the captured word
    logic [31:0]         wdata_q, wdata_d;
    logic                last_q, last_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, full_d;
    logic                err_q, err_d;

    logic [31:0]         enc_word;
    logic                class_legal;

    // Instruction encoder; shamt is always zero.
    always_comb begin
        enc_word    = '0;
        class_legal = 1'b1;
        case (in_class)
            3'd0:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_funct};
            3'd1:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
            3'd2:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
            3'd3:    enc_word = {6'b001000, in_rs, in_rt, in_imm};
            3'd4:    enc_word = {6'b000100, in_rs, in_rt, in_imm};
            3'd5:    enc_word = {6'b000010, in_target};
            default: class_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            next_addr_q <= '0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            last_q      <= 1'b0;
            count_q     <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            last_q      <= last_d;
            count_q     <= count_d;
            full_q      <= full_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        mem_addr_d  = mem_addr_q;
        wdata_d     = wdata_q;
        last_d      = last_q;
        count_d     = count_q;
        full_d      = full_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    next_addr_d = BASE_ADDR;
                    count_d     = '0;
                    full_d      = 1'b0;
                    err_d       = 1'b0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (class_legal) begin
                        wdata_d    = enc_word;
                        mem_addr_d = next_addr_q;
                        last_d     = in_last;
                        state_d    = S_WRITE;
                    end else begin
                        err_d = 1'b1;
                        if (in_last) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_WRITE: begin
                next_addr_d = next_addr_q + ADDR_ONE;
                count_d     = count_q + CNT_ONE;
                // Top of memory ends the session even without in_last.
                if (&mem_addr_q) begin
                    full_d  = 1'b1;
                    state_d = S_DONE;
                end else if (last_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes are masked by rst so a reset landing on the write cycle
    // suppresses the write instead of letting it through for one more cycle.
    assign in_ready  = (state_q == S_LOAD)  && !rst;
    assign mem_we    = (state_q == S_WRITE) && !rst;
    assign done      = (state_q == S_DONE)  && !rst;
    assign busy      = (state_q != S_IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = wdata_q;
    assign full      = full_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule
